// File: rtl/fp_add_seq_if.sv
// Bus-side handshake bundle for fp_add_seq: operand channel in, result channel out.
// master = producer/consumer side, slave = the sequencer.
interface fp_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        out_unf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_add_seq.sv
// Initiator-side sequencer for the registered FP adder wrapper: accept operands, pulse en LAT
// times, capture the result, hand it back. Optional statistics under FP_ADD_SEQ_STATS_EN.
module fp_add_seq #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  fp_add_seq_if.slave bus,
  output logic        add_en,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  input  logic        add_ovf,
  input  logic        add_unf,
`ifdef FP_ADD_SEQ_STATS_EN
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] exc_count,
`endif
  output logic        busy
);

  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     a_q, b_q;
  logic [31:0]     sum_q;
  logic            ovf_q, unf_q;
  logic            accept, capture, out_hs;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    out_hs  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        capture = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          out_hs  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Wrapper contents are deliberately not touched by reset; the next LAT en pulses flush them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
      if (capture) begin
        sum_q <= add_sum;
        ovf_q <= add_ovf;
        unf_q <= add_unf;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_unf   = unf_q;
  assign add_en        = (state_q == StIssue);
  assign add_a         = a_q;
  assign add_b         = b_q;
  assign busy          = (state_q != StIdle);

`ifdef FP_ADD_SEQ_STATS_EN
  logic [CNT_W-1:0] op_q, exc_q;

  // Clear has priority over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst || clr_stats) begin
      op_q  <= '0;
      exc_q <= '0;
    end else if (out_hs) begin
      if (op_q != '1) begin
        op_q <= op_q + 1'b1;
      end
      if ((ovf_q || unf_q) && (exc_q != '1)) begin
        exc_q <= exc_q + 1'b1;
      end
    end
  end

  assign op_count  = op_q;
  assign exc_count = exc_q;
`endif

endmodule
